// File: rtl/alu_branch_unit.sv
// Single-cycle ALU with ALU-control decode, signed branch comparator and a
// registered copy of the ALU result.
module alu_branch_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  input  logic [5:0]        OP,
  input  logic [5:0]        funct,
  input  logic [4:0]        shamt,
  input  logic [1:0]        ALUCtrlOp,
  input  logic [DATA_W-1:0] BrA,
  input  logic [DATA_W-1:0] BrB,
  input  logic [4:0]        BrFunct,
  output logic [5:0]        ALUOp,
  output logic [DATA_W-1:0] ALUResult,
  output logic [DATA_W-1:0] ALUResultReg,
  output logic              Zero,
  output logic              Overflow,
  output logic              BranchSucceed
);

  localparam logic [5:0] OP_ADD  = 6'd0,  OP_ADDU = 6'd1,  OP_SUB  = 6'd2;
  localparam logic [5:0] OP_SUBU = 6'd3,  OP_AND  = 6'd4,  OP_OR   = 6'd5;
  localparam logic [5:0] OP_XOR  = 6'd6,  OP_NOR  = 6'd7,  OP_SLT  = 6'd8;
  localparam logic [5:0] OP_SLTU = 6'd9,  OP_SLL  = 6'd10, OP_SRL  = 6'd11;
  localparam logic [5:0] OP_SRA  = 6'd12, OP_SLLV = 6'd13, OP_SRLV = 6'd14;
  localparam logic [5:0] OP_SRAV = 6'd15, OP_LUI  = 6'd16;

  logic signed [DATA_W-1:0] a_s, b_s, bra_s, brb_s;
  logic        [DATA_W-1:0] sum, diff;
  logic        [DATA_W-1:0] alu_result_d, alu_result_q;

  // Signed overflow: operands agree in sign (add) or differ (sub) and the
  // result's sign departs from operand A.
  function automatic logic add_ovf(input logic [DATA_W-1:0] a, b, r);
    return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  function automatic logic sub_ovf(input logic [DATA_W-1:0] a, b, r);
    return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  always_comb begin
    ALUOp = OP_ADD;
    unique case (ALUCtrlOp)
      2'b00: ALUOp = OP_ADD;
      2'b01: ALUOp = OP_SUB;
      2'b10: begin
        case (funct)
          6'h20: ALUOp = OP_ADD;
          6'h21: ALUOp = OP_ADDU;
          6'h22: ALUOp = OP_SUB;
          6'h23: ALUOp = OP_SUBU;
          6'h24: ALUOp = OP_AND;
          6'h25: ALUOp = OP_OR;
          6'h26: ALUOp = OP_XOR;
          6'h27: ALUOp = OP_NOR;
          6'h2A: ALUOp = OP_SLT;
          6'h2B: ALUOp = OP_SLTU;
          6'h00: ALUOp = OP_SLL;
          6'h02: ALUOp = OP_SRL;
          6'h03: ALUOp = OP_SRA;
          6'h04: ALUOp = OP_SLLV;
          6'h06: ALUOp = OP_SRLV;
          6'h07: ALUOp = OP_SRAV;
          default: ALUOp = OP_ADD;
        endcase
      end
      default: begin
        case (OP)
          6'h09: ALUOp = OP_ADDU;
          6'h0C: ALUOp = OP_AND;
          6'h0D: ALUOp = OP_OR;
          6'h0E: ALUOp = OP_XOR;
          6'h0A: ALUOp = OP_SLT;
          6'h0B: ALUOp = OP_SLTU;
          6'h0F: ALUOp = OP_LUI;
          default: ALUOp = OP_ADD;
        endcase
      end
    endcase
  end

  always_comb begin
    a_s       = SrcA;
    b_s       = SrcB;
    sum       = SrcA + SrcB;
    diff      = SrcA - SrcB;
    ALUResult = sum;
    Overflow  = 1'b0;
    case (ALUOp)
      OP_ADD:  begin ALUResult = sum;  Overflow = add_ovf(SrcA, SrcB, sum);  end
      OP_ADDU: ALUResult = sum;
      OP_SUB:  begin ALUResult = diff; Overflow = sub_ovf(SrcA, SrcB, diff); end
      OP_SUBU: ALUResult = diff;
      OP_AND:  ALUResult = SrcA & SrcB;
      OP_OR:   ALUResult = SrcA | SrcB;
      OP_XOR:  ALUResult = SrcA ^ SrcB;
      OP_NOR:  ALUResult = ~(SrcA | SrcB);
      OP_SLT:  ALUResult = {{(DATA_W-1){1'b0}}, a_s < b_s};
      OP_SLTU: ALUResult = {{(DATA_W-1){1'b0}}, SrcA < SrcB};
      OP_SLL:  ALUResult = SrcB << shamt;
      OP_SRL:  ALUResult = SrcB >> shamt;
      OP_SRA:  ALUResult = b_s >>> shamt;
      OP_SLLV: ALUResult = SrcB << SrcA[4:0];
      OP_SRLV: ALUResult = SrcB >> SrcA[4:0];
      OP_SRAV: ALUResult = b_s >>> SrcA[4:0];
      OP_LUI:  ALUResult = {SrcB[15:0], 16'h0000};
      default: ALUResult = sum;
    endcase
  end

  assign Zero = (ALUResult == '0);

  // Branch comparator reads the register file directly, not the ALU.
  always_comb begin
    bra_s         = BrA;
    brb_s         = BrB;
    BranchSucceed = 1'b0;
    case (OP)
      6'h04: BranchSucceed = (bra_s == brb_s);
      6'h05: BranchSucceed = (bra_s != brb_s);
      6'h06: BranchSucceed = (bra_s <= 0);
      6'h07: BranchSucceed = (bra_s > 0);
      6'h01: begin
        if (BrFunct == 5'b00000)      BranchSucceed = (bra_s < 0);
        else if (BrFunct == 5'b00001) BranchSucceed = (bra_s >= 0);
      end
      default: BranchSucceed = 1'b0;
    endcase
  end

  assign alu_result_d = ALUResult;

  always_ff @(posedge clk) begin
    if (rst) alu_result_q <= '0;
    else     alu_result_q <= alu_result_d;
  end

  assign ALUResultReg = alu_result_q;

endmodule

// File: tb/tb_alu_branch_unit.sv
// Directed table-driven bench for alu_branch_unit plus reset sequences.
module tb_alu_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] SrcA, SrcB, BrA, BrB;
  logic [5:0]  OP, funct, ALUOp;
  logic [4:0]  shamt, BrFunct;
  logic [1:0]  ALUCtrlOp;
  logic [31:0] ALUResult, ALUResultReg;
  logic        Zero, Overflow, BranchSucceed;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_branch_unit dut (
    .clk(clk), .rst(rst), .SrcA(SrcA), .SrcB(SrcB), .OP(OP), .funct(funct),
    .shamt(shamt), .ALUCtrlOp(ALUCtrlOp), .BrA(BrA), .BrB(BrB), .BrFunct(BrFunct),
    .ALUOp(ALUOp), .ALUResult(ALUResult), .ALUResultReg(ALUResultReg),
    .Zero(Zero), .Overflow(Overflow), .BranchSucceed(BranchSucceed)
  );

  typedef struct {
    logic [1:0]  ctrl;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] a, b, bra, brb;
    logic [4:0]  brf;
    logic [5:0]  e_op;
    logic [31:0] e_res;
    logic        e_ovf;
    logic        e_br;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] ctrl, input logic [5:0] op, fn,
                              input logic [4:0] sh, input logic [31:0] a, b, bra, brb,
                              input logic [4:0] brf, input logic [5:0] e_op,
                              input logic [31:0] e_res, input logic e_ovf, e_br);
    vec_t v;
    v.ctrl = ctrl; v.op = op; v.fn = fn; v.sh = sh; v.a = a; v.b = b;
    v.bra = bra; v.brb = brb; v.brf = brf; v.e_op = e_op; v.e_res = e_res;
    v.e_ovf = e_ovf; v.e_br = e_br;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    ALUCtrlOp = v.ctrl; OP = v.op; funct = v.fn; shamt = v.sh;
    SrcA = v.a; SrcB = v.b; BrA = v.bra; BrB = v.brb; BrFunct = v.brf;
  endtask

  initial begin
    rst = 1'b1;
    apply(mk(2'b00, 6'h00, 6'h00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 6'd0, 32'h0, 1'b0, 1'b0));

    //        ctrl   OP     funct  sh  SrcA          SrcB          BrA           BrB     BrF  ALUOp  result        ovf br
    vecs.push_back(mk(2'b00, 6'h00, 6'h00, 5'd0,  32'h00003000, 32'h00000004, 32'h0, 32'h0, 5'd0, 6'd0,  32'h00003004, 0, 0));
    vecs.push_back(mk(2'b10, 6'h00, 6'h20, 5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h0, 32'h0, 5'd0, 6'd0,  32'h80000000, 1, 0));
    vecs.push_back(mk(2'b10, 6'h00, 6'h21, 5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h0, 32'h0, 5'd0, 6'd1,  32'h80000000, 0, 0));
    vecs.push_back(mk(2'b10, 6'h00, 6'h2A, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h0, 5'd0, 6'd8,  32'h00000001, 0, 0));
    vecs.push_back(mk(2'b10, 6'h00, 6'h2B, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h0, 5'd0, 6'd9,  32'h00000000, 0, 0));
    vecs.push_back(mk(2'b10, 6'h00, 6'h03, 5'd4,  32'h00000000, 32'h80000000, 32'h0, 32'h0, 5'd0, 6'd12, 32'hF8000000, 0, 0));
    vecs.push_back(mk(2'b11, 6'h0F, 6'h00, 5'd0,  32'h00000000, 32'h00001234, 32'h0, 32'h0, 5'd0, 6'd16, 32'h12340000, 0, 0));
    vecs.push_back(mk(2'b11, 6'h0D, 6'h00, 5'd0,  32'h12340000, 32'h00005678, 32'h0, 32'h0, 5'd0, 6'd5,  32'h12345678, 0, 0));
    vecs.push_back(mk(2'b10, 6'h00, 6'h22, 5'd0,  32'h80000000, 32'h00000001, 32'h0, 32'h0, 5'd0, 6'd2,  32'h7FFFFFFF, 1, 0));
    vecs.push_back(mk(2'b10, 6'h00, 6'h23, 5'd0,  32'h80000000, 32'h00000001, 32'h0, 32'h0, 5'd0, 6'd3,  32'h7FFFFFFF, 0, 0));
    vecs.push_back(mk(2'b10, 6'h00, 6'h27, 5'd0,  32'h00000000, 32'h00000000, 32'h0, 32'h0, 5'd0, 6'd7,  32'hFFFFFFFF, 0, 0));
    vecs.push_back(mk(2'b10, 6'h00, 6'h26, 5'd0,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0, 32'h0, 5'd0, 6'd6,  32'hF00FF00F, 0, 0));
    vecs.push_back(mk(2'b10, 6'h00, 6'h24, 5'd0,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0, 32'h0, 5'd0, 6'd4,  32'h0F000F00, 0, 0));
    vecs.push_back(mk(2'b10, 6'h00, 6'h25, 5'd0,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0, 32'h0, 5'd0, 6'd5,  32'hFF0FFF0F, 0, 0));
    vecs.push_back(mk(2'b10, 6'h00, 6'h07, 5'd0,  32'h00000024, 32'h80000010, 32'h0, 32'h0, 5'd0, 6'd15, 32'hF8000001, 0, 0));
    vecs.push_back(mk(2'b10, 6'h00, 6'h04, 5'd0,  32'h00000003, 32'h00000001, 32'h0, 32'h0, 5'd0, 6'd13, 32'h00000008, 0, 0));
    vecs.push_back(mk(2'b10, 6'h00, 6'h06, 5'd0,  32'h0000001F, 32'h80000000, 32'h0, 32'h0, 5'd0, 6'd14, 32'h00000001, 0, 0));
    vecs.push_back(mk(2'b10, 6'h00, 6'h00, 5'd31, 32'h00000000, 32'h00000001, 32'h0, 32'h0, 5'd0, 6'd10, 32'h80000000, 0, 0));
    vecs.push_back(mk(2'b10, 6'h00, 6'h02, 5'd1,  32'h00000000, 32'h80000000, 32'h0, 32'h0, 5'd0, 6'd11, 32'h40000000, 0, 0));
    vecs.push_back(mk(2'b10, 6'h00, 6'h3F, 5'd0,  32'h00000001, 32'h00000002, 32'h0, 32'h0, 5'd0, 6'd0,  32'h00000003, 0, 0));
    vecs.push_back(mk(2'b01, 6'h04, 6'h00, 5'd0,  32'h00000005, 32'h00000005, 32'd5, 32'd5, 5'd0, 6'd2,  32'h00000000, 0, 1));
    vecs.push_back(mk(2'b11, 6'h01, 6'h00, 5'd0,  32'h00000000, 32'h00000000, 32'h80000000, 32'h0, 5'd1, 6'd0, 32'h0, 0, 0));
    vecs.push_back(mk(2'b00, 6'h07, 6'h00, 5'd0,  32'h00000010, 32'h00000020, 32'd1, 32'h0, 5'd0, 6'd0,  32'h00000030, 0, 1));
    vecs.push_back(mk(2'b11, 6'h08, 6'h00, 5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h0, 32'h0, 5'd0, 6'd0,  32'h80000000, 1, 0));
    vecs.push_back(mk(2'b00, 6'h05, 6'h00, 5'd0,  32'h00000000, 32'h00000000, 32'd1, 32'd2, 5'd0, 6'd0,  32'h00000000, 0, 1));
    vecs.push_back(mk(2'b00, 6'h05, 6'h00, 5'd0,  32'h00000000, 32'h00000000, 32'd2, 32'd2, 5'd0, 6'd0,  32'h00000000, 0, 0));
    vecs.push_back(mk(2'b00, 6'h06, 6'h00, 5'd0,  32'h00000000, 32'h00000000, 32'd0, 32'h0, 5'd0, 6'd0,  32'h00000000, 0, 1));
    vecs.push_back(mk(2'b00, 6'h06, 6'h00, 5'd0,  32'h00000000, 32'h00000000, 32'd1, 32'h0, 5'd0, 6'd0,  32'h00000000, 0, 0));
    vecs.push_back(mk(2'b00, 6'h07, 6'h00, 5'd0,  32'h00000000, 32'h00000000, 32'd0, 32'h0, 5'd0, 6'd0,  32'h00000000, 0, 0));
    vecs.push_back(mk(2'b00, 6'h01, 6'h00, 5'd0,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 5'd0, 6'd0, 32'h0, 0, 1));
    vecs.push_back(mk(2'b00, 6'h01, 6'h00, 5'd0,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 5'd2, 6'd0, 32'h0, 0, 0));
    vecs.push_back(mk(2'b00, 6'h01, 6'h00, 5'd0,  32'h00000000, 32'h00000000, 32'h00000000, 32'h0, 5'd1, 6'd0, 32'h0, 0, 1));
    vecs.push_back(mk(2'b11, 6'h0A, 6'h00, 5'd0,  32'h00000001, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 6'd8,  32'h00000000, 0, 0));
    vecs.push_back(mk(2'b11, 6'h0B, 6'h00, 5'd0,  32'h00000001, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 6'd9,  32'h00000001, 0, 0));
    vecs.push_back(mk(2'b11, 6'h0E, 6'h00, 5'd0,  32'h0000FFFF, 32'h000000FF, 32'h0, 32'h0, 5'd0, 6'd6,  32'h0000FF00, 0, 0));
    vecs.push_back(mk(2'b11, 6'h23, 6'h00, 5'd0,  32'h00000100, 32'h00000004, 32'h0, 32'h0, 5'd0, 6'd0,  32'h00000104, 0, 0));

    // Reset state, with combinational outputs live during reset.
    @(posedge clk); #1;
    check("reset_reg", ALUResultReg, 32'h0);
    @(negedge clk);
    SrcA = 32'h00000002; SrcB = 32'h00000003;
    #1;
    check("reset_comb_tracks", ALUResult, 32'h00000005);
    @(posedge clk); #1;
    check("reset_reg_held", ALUResultReg, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check($sformatf("v%0d_aluop", i), {26'h0, ALUOp}, {26'h0, vecs[i].e_op});
      check($sformatf("v%0d_result", i), ALUResult, vecs[i].e_res);
      check($sformatf("v%0d_zero", i), {31'h0, Zero}, {31'h0, vecs[i].e_res == 32'h0});
      check($sformatf("v%0d_ovf", i), {31'h0, Overflow}, {31'h0, vecs[i].e_ovf});
      check($sformatf("v%0d_branch", i), {31'h0, BranchSucceed}, {31'h0, vecs[i].e_br});
      @(posedge clk); #1;
      check($sformatf("v%0d_reg", i), ALUResultReg, vecs[i].e_res);
    end

    // Mid-stream reset: load 0x1234, reset overrides one edge, then reload.
    @(negedge clk);
    ALUCtrlOp = 2'b00; SrcA = 32'h00001230; SrcB = 32'h00000004;
    @(posedge clk); #1;
    check("mid_load", ALUResultReg, 32'h00001234);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_reg", ALUResultReg, 32'h0);
    check("mid_reset_comb", ALUResult, 32'h00001234);
    @(negedge clk);
    rst = 1'b0; SrcA = 32'h00000000; SrcB = 32'h00000001;
    #1;
    check("post_reset_reg_before_edge", ALUResultReg, 32'h0);
    @(posedge clk); #1;
    check("post_reset_load", ALUResultReg, 32'h00000001);

    // Back-to-back loads: register follows every edge with one-cycle lag.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      SrcA = 32'h00000100 * k; SrcB = 32'h00000011;
      @(posedge clk); #1;
      check($sformatf("stream%0d", k), ALUResultReg, 32'h00000100 * k + 32'h11);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
